// File: rtl/conv_pkg.sv
// Shared constants and types for the convolution output path.
package conv_pkg;

  localparam int NUM_CONV_FILTERS = 6;
  localparam int FEATURE_W        = 16;

  // Occupancy of the two-slot ping-pong buffer.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/feature_requant.sv
// Requantises one signed feature: optional round-half-up, arithmetic right
// shift, then saturate or wrap to OUT_W bits with an out-of-range flag.
module feature_requant #(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 8,
  parameter int SHIFT    = 4,
  parameter int ROUND_EN = 1,
  parameter int SAT_EN   = 1
) (
  input  logic signed [IN_W-1:0]  data_i,
  output logic signed [OUT_W-1:0] value_o,
  output logic                    sat_o
);

  // One extra bit of headroom means the rounding add can never overflow.
  localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [IN_W:0] RND =
    (ROUND_EN != 0 && SHIFT > 0) ? (IN_W+1)'(1 << RND_SH) : '0;
  localparam logic signed [IN_W:0] MAX_V = (IN_W+1)'((1 << (OUT_W-1)) - 1);
  localparam logic signed [IN_W:0] MIN_V = (IN_W+1)'(-(1 << (OUT_W-1)));

  logic signed [IN_W:0] ext;
  logic signed [IN_W:0] sum;
  logic signed [IN_W:0] shifted;

  assign ext     = {data_i[IN_W-1], data_i};
  assign sum     = ext + RND;
  assign shifted = sum >>> SHIFT;

  // Range check and clamp/wrap; the flag means "output differs from exact".
  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    value_o = shifted[OUT_W-1:0];
    sat_o   = (shifted > MAX_V) || (shifted < MIN_V);
    if (SAT_EN != 0) begin
      if (shifted > MAX_V)      value_o = MAX_V[OUT_W-1:0];
      else if (shifted < MIN_V) value_o = MIN_V[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/requant_serializer.sv
// Accepts NUM_CH parallel features per beat into a two-slot ping-pong buffer
// and emits them one channel per cycle, requantised, with valid/ready on both
// sides and a saturating count of clamped outputs.
module requant_serializer
  import conv_pkg::*;
#(
  parameter int NUM_CH   = NUM_CONV_FILTERS,
  parameter int IN_W     = FEATURE_W,
  parameter int OUT_W    = 8,
  parameter int SHIFT    = 4,
  parameter int ROUND_EN = 1,
  parameter int SAT_EN   = 1
) (
  input  logic                                      i_clk,
  input  logic                                      i_rst_n,
  input  logic                                      i_valid,
  output logic                                      o_ready,
  input  logic [NUM_CH-1:0][IN_W-1:0]               i_features,
  input  logic                                      i_last,
  output logic                                      o_valid,
  input  logic                                      i_ready,
  output logic signed [OUT_W-1:0]                   o_feature,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] o_ch,
  output logic                                      o_last,
  output logic                                      o_sat,
  output logic [15:0]                               o_sat_count
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  occ_e            occ_q, occ_d;
  logic            head_q, head_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic [15:0]     sat_cnt_q, sat_cnt_d;

  logic [NUM_CH-1:0][IN_W-1:0] slot_data_q [2];
  logic [1:0]                  slot_last_q;

  logic                   in_fire;
  logic                   out_fire;
  logic                   beat_done;
  logic                   wr_ptr;
  logic signed [IN_W-1:0] head_feat;
  logic signed [OUT_W-1:0] rq_value;
  logic                   rq_sat;

  assign o_ready   = (occ_q != OCC_TWO);
  assign o_valid   = (occ_q != OCC_EMPTY);
  assign in_fire   = i_valid && o_ready;
  assign out_fire  = o_valid && i_ready;
  assign beat_done = out_fire && (ch_q == LAST_CH);
  // A lone beat sits in the head slot; the second beat goes to the other one.
  assign wr_ptr    = head_q ^ (occ_q != OCC_EMPTY);
  assign head_feat = slot_data_q[head_q][ch_q];

  feature_requant #(
    .IN_W     (IN_W),
    .OUT_W    (OUT_W),
    .SHIFT    (SHIFT),
    .ROUND_EN (ROUND_EN),
    .SAT_EN   (SAT_EN)
  ) u_requant (
    .data_i  (head_feat),
    .value_o (rq_value),
    .sat_o   (rq_sat)
  );

  assign o_feature   = rq_value;
  assign o_ch        = ch_q;
  assign o_sat       = o_valid && rq_sat;
  assign o_last      = o_valid && slot_last_q[head_q] && (ch_q == LAST_CH);
  assign o_sat_count = sat_cnt_q;

  // Next-state: occupancy, head pointer, channel index and clamp counter.
  always_comb begin
    occ_d     = occ_q;
    head_d    = head_q;
    ch_d      = ch_q;
    sat_cnt_d = sat_cnt_q;
    if (out_fire) begin
      if (o_sat && sat_cnt_q != 16'hFFFF) sat_cnt_d = sat_cnt_q + 16'd1;
      ch_d = beat_done ? '0 : ch_q + CH_W'(1);
      if (beat_done) head_d = ~head_q;
    end
    if (in_fire && !beat_done) begin
      case (occ_q)
        OCC_EMPTY: occ_d = OCC_ONE;
        OCC_ONE:   occ_d = OCC_TWO;
        default:   occ_d = occ_q;
      endcase
    end else if (!in_fire && beat_done) begin
      case (occ_q)
        OCC_TWO: occ_d = OCC_ONE;
        OCC_ONE: occ_d = OCC_EMPTY;
        default: occ_d = occ_q;
      endcase
    end
  end

  // Control state register; reset discards both slots.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      occ_q     <= OCC_EMPTY;
      head_q    <= 1'b0;
      ch_q      <= '0;
      sat_cnt_q <= '0;
    end else begin
      occ_q     <= occ_d;
      head_q    <= head_d;
      ch_q      <= ch_d;
      sat_cnt_q <= sat_cnt_d;
    end
  end

  // Buffer slot write on input transfer.
  // NOTE: slot storage is deliberately unreset; occupancy alone says what is valid.
  always_ff @(posedge i_clk) begin
    if (in_fire) begin
      slot_data_q[wr_ptr] <= i_features;
      slot_last_q[wr_ptr] <= i_last;
    end
  end

endmodule

// File: tb/tb_requant_serializer.sv
// Self-checking bench for requant_serializer with a queue-based reference model.
module tb_requant_serializer;

  localparam int NUM_CH = 6;

  typedef struct packed {
    logic                   last;
    logic [NUM_CH-1:0][15:0] f;
  } beat_t;

  logic                    i_clk = 1'b0;
  logic                    i_rst_n;
  logic                    i_valid;
  logic                    o_ready;
  logic [NUM_CH-1:0][15:0] i_features;
  logic                    i_last;
  logic                    o_valid;
  logic                    i_ready;
  logic signed [7:0]       o_feature;
  logic [2:0]              o_ch;
  logic                    o_last;
  logic                    o_sat;
  logic [15:0]             o_sat_count;

  int    checks = 0;
  int    errors = 0;
  beat_t mq[$];
  int    m_ch  = 0;
  int    m_cnt = 0;

  always #5 i_clk = ~i_clk;

  requant_serializer dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_features  (i_features),
    .i_last      (i_last),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_feature   (o_feature),
    .o_ch        (o_ch),
    .o_last      (o_last),
    .o_sat       (o_sat),
    .o_sat_count (o_sat_count)
  );

  // Exact result: floor((x + 8) / 16), computed with integer division.
  function automatic int rq_exact(logic signed [15:0] x);
    int v;
    v = int'(x) + 8;
    if (v >= 0) return v / 16;
    return -((-v + 15) / 16);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic check_outputs();
    int e;
    int c;
    bit s;
    chk("o_valid", 32'(o_valid), 32'(mq.size() > 0));
    chk("o_ready", 32'(o_ready), 32'(mq.size() < 2));
    chk("o_sat_count", 32'(o_sat_count), 32'(m_cnt));
    if (mq.size() > 0) begin
      e = rq_exact(mq[0].f[m_ch]);
      s = (e > 127) || (e < -128);
      c = (e > 127) ? 127 : (e < -128) ? -128 : e;
      chk("o_feature", 32'(o_feature), 32'(c));
      chk("o_ch", 32'(o_ch), 32'(m_ch));
      chk("o_last", 32'(o_last), 32'(mq[0].last && m_ch == NUM_CH - 1));
      chk("o_sat", 32'(o_sat), 32'(s));
    end else begin
      chk("o_last_idle", 32'(o_last), 32'(0));
      chk("o_sat_idle", 32'(o_sat), 32'(0));
    end
  endtask

  // Advance one clock, update the model with the transfers at that edge, check.
  task automatic step();
    bit    out_f;
    bit    in_f;
    bit    s_now;
    int    e;
    beat_t nb;
    out_f   = (mq.size() > 0) && i_ready;
    in_f    = i_valid && (mq.size() < 2);
    nb.last = i_last;
    nb.f    = i_features;
    s_now   = 1'b0;
    if (mq.size() > 0) begin
      e     = rq_exact(mq[0].f[m_ch]);
      s_now = (e > 127) || (e < -128);
    end
    @(posedge i_clk);
    #1;
    if (out_f) begin
      if (s_now && m_cnt < 65535) m_cnt++;
      if (m_ch == NUM_CH - 1) begin
        void'(mq.pop_front());
        m_ch = 0;
      end else begin
        m_ch++;
      end
    end
    if (in_f) mq.push_back(nb);
    check_outputs();
  endtask

  task automatic set_beat(int a, int b, int c, int d, int e, int f, bit last);
    i_features[0] = 16'(a);
    i_features[1] = 16'(b);
    i_features[2] = 16'(c);
    i_features[3] = 16'(d);
    i_features[4] = 16'(e);
    i_features[5] = 16'(f);
    i_last        = last;
  endtask

  task automatic rand_beat();
    for (int c = 0; c < NUM_CH; c++) begin
      if ($urandom_range(0, 1) == 1) i_features[c] = 16'($urandom);
      else                          i_features[c] = 16'(int'($urandom_range(0, 8191)) - 4096);
    end
    i_last = 1'($urandom_range(0, 1));
  endtask

  initial begin
    logic [7:0] held_feat;
    bit         acc;

    i_rst_n    = 1'b0;
    i_valid    = 1'b0;
    i_ready    = 1'b0;
    i_last     = 1'b0;
    i_features = '0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
    check_outputs();
    chk("reset_o_ch", 32'(o_ch), 32'(0));

    // Rounding, negative rounding, and both clamp directions.
    set_beat(24, -24, 7, 8, 32'h7FFF, -32768, 1'b0);
    i_valid = 1'b1;
    i_ready = 1'b1;
    step();
    i_valid = 1'b0;
    repeat (6) step();
    chk("sat_count_after_clamps", 32'(o_sat_count), 32'(2));

    // Back-to-back beats: twelve outputs in twelve consecutive cycles.
    rand_beat();
    i_last  = 1'b1;
    i_valid = 1'b1;
    step();
    rand_beat();
    i_last = 1'b0;
    for (int k = 0; k < 2 * NUM_CH; k++) begin
      chk("b2b_o_valid", 32'(o_valid), 32'(1));
      step();
      i_valid = 1'b0;
    end
    chk("b2b_drained", 32'(o_valid), 32'(0));

    // Downstream stall at channel 2 holds the presented output.
    rand_beat();
    i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    repeat (2) step();
    held_feat = o_feature;
    i_ready   = 1'b0;
    repeat (3) begin
      step();
      chk("stall_o_ch", 32'(o_ch), 32'(2));
      chk("stall_o_feature", 32'(o_feature), 32'(held_feat));
    end
    i_ready = 1'b1;
    step();
    chk("resume_o_ch", 32'(o_ch), 32'(3));
    repeat (4) step();

    // Reset in the middle of a full buffer.
    i_ready = 1'b0;
    i_valid = 1'b1;
    rand_beat();
    step();
    rand_beat();
    step();
    i_valid = 1'b0;
    i_ready = 1'b1;
    repeat (3) step();
    i_rst_n = 1'b0;
    mq.delete();
    m_ch  = 0;
    m_cnt = 0;
    #1;
    chk("rst_o_valid", 32'(o_valid), 32'(0));
    chk("rst_sat_count", 32'(o_sat_count), 32'(0));
    chk("rst_o_ch", 32'(o_ch), 32'(0));
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
    check_outputs();
    rand_beat();
    i_valid = 1'b1;
    step();
    chk("post_rst_ch0", 32'(o_ch), 32'(0));
    i_valid = 1'b0;
    repeat (NUM_CH) step();

    // Randomised traffic; a refused beat is held until taken.
    rand_beat();
    i_valid = 1'($urandom_range(0, 1));
    for (int k = 0; k < 400; k++) begin
      i_ready = ($urandom_range(0, 3) != 0);
      acc     = i_valid && o_ready;
      step();
      if (acc || !i_valid) begin
        rand_beat();
        i_valid = ($urandom_range(0, 2) != 0);
      end
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    repeat (2 * NUM_CH + 2) step();
    chk("final_drained", 32'(o_valid), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
